// File: rtl/rv32_pkg.sv
// RV32I opcode constants, format enum and NOP word shared by the encoder.
// Imported by instr_pack and instr_encoder.
package rv32_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer: format decode, immediate range check, packing.
// Ports: opcode/rd/rs1/rs2/funct3/funct7/imm in; instr word and legal out.
module instr_pack
  import rv32_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  fmt_e fmt;

  always_comb begin
    unique case (opcode)
      OP:                 fmt = FMT_R;
      OP_IMM, LOAD, JALR: fmt = FMT_I;
      STORE:              fmt = FMT_S;
      BRANCH:             fmt = FMT_B;
      LUI, AUIPC:         fmt = FMT_U;
      JAL:                fmt = FMT_J;
      default:            fmt = FMT_BAD;
    endcase
  end

  // In range: every bit above the top encoded bit matches it.
  logic fit12, fit13, fit21;
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    instr = NOP;
    legal = 1'b0;
    unique case (fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        legal = fit12;
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        legal = fit12;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                 imm[4:1], imm[11], opcode};
        legal = fit13 & ~imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        legal = ~(|imm[11:0]);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        legal = fit21 & ~imm[0];
      end
      default: begin
        instr = NOP;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field encoder with one registered valid/ready output stage.
// Ports: clk/rst/clr, field bundle in (valid/ready), instr/addr/err out, err_count.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  output logic [15:0]       err_count
);

  logic [31:0]       word;
  logic              legal;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              in_fire;
  logic              out_fire;

  instr_pack u_pack (
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    (imm),
    .instr  (word),
    .legal  (legal)
  );

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Counter value after this edge; a newly loaded beat takes it.
  always_comb begin
    cnt_nxt = cnt;
    if (clr)           cnt_nxt = '0;
    else if (out_fire) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      instr     <= '0;
      addr      <= '0;
      err       <= 1'b0;
      err_count <= '0;
      cnt       <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (in_fire) begin
        out_valid <= 1'b1;
        instr     <= legal ? word : NOP_WORD;
        err       <= !legal;
        addr      <= cnt_nxt;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
      if (clr)
        err_count <= '0;
      else if (in_fire && !legal && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=2) with a scoreboard queue.
// Directed steps in one initial block; a negedge monitor pops and compares.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_ready;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid, out_ready;
  logic [31:0] instr;
  logic [1:0]  addr;
  logic        err;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  exp_cnt;
  logic [15:0] exp_ec;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .addr      (addr),
    .err       (err),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compare every output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_instr", instr, e.instr);
        chk("beat_addr", {30'd0, addr}, {30'd0, e.addr});
        chk("beat_err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  // Drive at posedge+1, transfer at the first edge with in_ready high.
  task automatic send(input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [2:0] f3, input logic [31:0] im,
                      input logic [31:0] ew, input logic ee);
    exp_t e;
    int n;
    opcode = op; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = 7'd0; imm = im;
    in_valid = 1'b1;
    e.instr = ew; e.addr = exp_cnt; e.err = ee;
    sb.push_back(e);
    exp_cnt = exp_cnt + 2'd1;
    if (ee && exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [1:0] x_addr;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
    funct3 = '0; funct7 = '0; imm = '0;
    exp_cnt = '0; exp_ec = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", {30'd0, addr}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back beats, address wraps 0,1,2,3,0,1,...
    out_ready = 1'b1;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 1'b0);
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020A423, 1'b0);
    send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 32'hFFDFF06F, 1'b0);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd8, 32'h00000463, 1'b0);
    send(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 32'h123452B7, 1'b0);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h00000013, 1'b1);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd7, 32'h00000013, 1'b1);
    send(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h00000013, 1'b1);
    idle(2);
    @(negedge clk);
    chk("err_count_3", {16'd0, err_count}, {16'd0, exp_ec});
    @(posedge clk); #1;

    // Range boundaries.
    send(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd2048, 32'h80000013, 1'b0);
    send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1048574, 32'h7FFFF06F, 1'b0);
    send(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 32'd1048576, 32'h00000013, 1'b1);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4096, 32'h80000063, 1'b0);
    idle(2);
    @(negedge clk);
    chk("err_count_4", {16'd0, err_count}, {16'd0, exp_ec});
    @(posedge clk); #1;

    // Backpressure: hold one word, keep a second pending.
    out_ready = 1'b0;
    x_addr = exp_cnt;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 1'b0);
    opcode = 7'h23; rd = 5'd0; rs1 = 5'd1; rs2 = 5'd2;
    funct3 = 3'd2; imm = 32'd8; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_instr", instr, 32'h00500093);
      chk("stall_addr", {30'd0, addr}, {30'd0, x_addr});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020A423, 1'b0);
    idle(2);
    chk("drain_stall", sb.size(), 32'd0);

    // clr coincident with the output transfer of an in-flight beat.
    send(7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 32'd0, 32'h005201B3, 1'b0);
    clr = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_cnt = '0; exp_ec = '0;
    @(negedge clk);
    chk("clr_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk); #1;
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093, 1'b0);
    idle(2);

    // rst while a word is stalled: word dropped.
    out_ready = 1'b0;
    send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd1, 32'h00100113, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_cnt = '0; exp_ec = '0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_addr", {30'd0, addr}, 32'd0);
    chk("mid_rst_err_count", {16'd0, err_count}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'h17, 5'd7, 5'd0, 5'd0, 3'd0, 32'hFFFFF000, 32'hFFFFF397, 1'b0);
    idle(3);
    chk("final_drain", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
